// File: rtl/seg_scan_arb_if.sv
// Display arbitration bus: two requesters in, frame snapshot, digit pointer and grants out.
interface seg_scan_arb_if;
    logic        src0_req;
    logic [15:0] src0_val;
    logic        src1_req;
    logic [15:0] src1_val;
    logic [15:0] count_val;
    logic [1:0]  dig_pointer;
    logic        src0_gnt;
    logic        src1_gnt;
    logic        frame_done;

    modport master (
        output src0_req, src0_val, src1_req, src1_val,
        input  count_val, dig_pointer, src0_gnt, src1_gnt, frame_done
    );

    modport slave (
        input  src0_req, src0_val, src1_req, src1_val,
        output count_val, dig_pointer, src0_gnt, src1_gnt, frame_done
    );
endinterface

// File: rtl/seg_scan_arb.sv
// Seven-segment scan scheduler and two-requester display arbiter; value and owner
// change only at frame boundaries so all four digits show one coherent snapshot.
module seg_scan_arb #(
    parameter int CLK_DIV     = 50000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_arb_if.slave bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [1:0]        ptr;
    logic [15:0]       snap, snap_d;
    logic              gnt0, gnt1, fdone;
    logic              tick, fb;

    assign tick = (div_cnt == DIV_LAST);
    assign fb   = tick && (ptr == 2'd3);

    // Prescaler, digit pointer and frame-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            ptr     <= 2'd0;
            fdone   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                ptr <= ptr + 2'd1;
            fdone <= fb;
        end
    end

    // Arbitration state, hold counter, snapshot and grants
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            snap     <= 16'h0000;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            snap     <= snap_d;
            gnt0     <= (state_d == OWN0);
            gnt1     <= (state_d == OWN1);
        end
    end

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        snap_d  = snap;
        if (fb) begin
            case (state)
                IDLE: begin
                    if (bus.src0_req) begin
                        state_d = OWN0;
                        hold_d  = '0;
                    end else if (bus.src1_req) begin
                        state_d = OWN1;
                        hold_d  = '0;
                    end
                end
                OWN0: begin
                    if (bus.src0_req && hold_cnt < HOLD_LAST) begin
                        hold_d = hold_cnt + 1'b1;
                    end else if (bus.src1_req) begin
                        state_d = OWN1;
                        hold_d  = '0;
                    end else if (bus.src0_req) begin
                        hold_d = HOLD_LAST;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                OWN1: begin
                    if (bus.src1_req && hold_cnt < HOLD_LAST) begin
                        hold_d = hold_cnt + 1'b1;
                    end else if (bus.src0_req) begin
                        state_d = OWN0;
                        hold_d  = '0;
                    end else if (bus.src1_req) begin
                        hold_d = HOLD_LAST;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
            // An idle display keeps showing the last owner's value
            case (state_d)
                OWN0:    snap_d = bus.src0_val;
                OWN1:    snap_d = bus.src1_val;
                default: snap_d = snap;
            endcase
        end
    end

    assign bus.count_val   = snap;
    assign bus.dig_pointer = ptr;
    assign bus.src0_gnt    = gnt0;
    assign bus.src1_gnt    = gnt1;
    assign bus.frame_done  = fdone;
endmodule

// File: doc/seg_scan_arb.md
# seg_scan_arb

Scan scheduler and display arbiter for the four-digit seven-segment display.
- Generates the multiplexing digit pointer for the display decoder.
- Arbitrates the 16-bit displayed value between two requesters, e.g. PC trace and register/debug value.
- Snapshots the winner's value only at frame boundaries, so all four digits always show one coherent value.
- Sits between the pipeline debug taps and the display decoder.

## Interface
Parameters:
- CLK_DIV, 50000, clk cycles per digit slot. Legal values are ≥ 1; 1 means the pointer advances every cycle.
- HOLD_FRAMES, 4, minimum number of frames an owner keeps the display before a contending requester can take it. Legal values are ≥ 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- src0_req  in  1  requester 0 wants the display (level).
- src0_val  in  16  requester 0 value, four hex nibbles.
- src1_req  in  1  requester 1 wants the display (level).
- src1_val  in  16  requester 1 value.
- count_val  out  16  registered frame snapshot driven to the decoder.
- dig_pointer  out  2  registered digit select: 0 = nibble [3:0], up to 3 = nibble [15:12].
- src0_gnt  out  1  registered; requester 0 currently owns the display.
- src1_gnt  out  1  registered; requester 1 currently owns the display.
- frame_done  out  1  one-cycle pulse marking a frame boundary.

## Operation
- **Prescaler.**
  - `div_cnt` counts 0 to CLK_DIV-1 and wraps to 0.
  - `tick` = (`div_cnt` == CLK_DIV-1).
  - Width is max(1, clog2(CLK_DIV)).
- **Digit pointer.** On each tick, `dig_pointer` advances by 1 mod 4 (3 wraps to 0).
- **Frame boundary.** A boundary (`fb`) is a tick while `dig_pointer` == 3. Arbitration, snapshot and hold counting happen only at `fb`.
- **FSM states:** IDLE, OWN0, OWN1. Grants are a one-hot decode of the state; both are 0 in IDLE.
- **From IDLE at fb:**
  - src0_req → OWN0 (src0 wins ties).
  - Else src1_req → OWN1.
  - Else stay IDLE.
- **From OWNx at fb** (y = the other requester), first matching rule applies:
  1. req_x and hold_cnt < HOLD_FRAMES-1 → stay; hold_cnt increments.
  2. req_y → go to OWNy; hold_cnt = 0.
  3. req_x → stay; hold_cnt saturates at HOLD_FRAMES-1.
  4. Otherwise → IDLE; hold_cnt = 0.
- **hold_cnt** is cleared on every acquisition. Its width is max(1, clog2(HOLD_FRAMES)).
- **Snapshot.**
  - At fb, `count_val` loads the value of the next-state owner.
  - In IDLE (next state), `count_val` holds its previous value.
  - Between boundaries, `count_val` is frozen regardless of the src*_val inputs.
- Requests and values are sampled only at fb. Toggling mid-frame has no effect, and pulses shorter than a frame may be missed; this is by design.
- **Reset** (rst high at a clk edge) forces:
  - `div_cnt` = 0, `dig_pointer` = 0, `count_val` = 16'h0000.
  - State IDLE, hold_cnt = 0, both grants 0, `frame_done` 0.
  - Reset asserted mid-frame or mid-ownership aborts immediately; nothing is retained.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `dig_pointer` changes on the edge where `tick` is true, giving exactly CLK_DIV cycles per digit value.
- A frame is 4×CLK_DIV cycles.
- Grant, `count_val` and `dig_pointer` (3→0) all update on the same fb edge.
- `frame_done` is high for exactly one cycle: the cycle after the fb edge, i.e. the first cycle with `dig_pointer` == 0 of the new frame.
- After rst deasserts:
  - The first tick occurs CLK_DIV cycles later.
  - The first fb occurs 4×CLK_DIV cycles later.
  - Until then, the display shows 0000 with no owner.
- Worst-case latency from a request to a grant:
  - From IDLE: 1 frame.
  - Against a continuously requesting owner: HOLD_FRAMES frames (the boundary after the owner's hold expires).
- With CLK_DIV = 1, `tick` is held constantly high and `dig_pointer` cycles 0,1,2,3 every cycle.

## Test plan
Bench parameters: CLK_DIV=4, HOLD_FRAMES=2 (frame = 16 cycles).

1. **Reset and scan.**
   - Stimulus: release rst with no requests.
   - Required: `dig_pointer` holds each of 0,1,2,3 for 4 cycles, repeating. `frame_done` pulses every 16 cycles, first at cycle 17. `count_val` = 0000, both grants 0.
2. **Single owner.**
   - Stimulus: src0_req=1, src0_val=16'h1234.
   - Required: at the first fb, src0_gnt=1 and count_val=1234. Change src0_val to ABCD mid-frame: count_val stays 1234 until the next fb, then becomes ABCD.
3. **Tie and fairness.**
   - Stimulus: both requests held high from reset, src0_val=1111, src1_val=2222.
   - Required: OWN0 for 2 frames, then OWN1 for 2 frames, then alternating. count_val alternates 1111/2222 on every second fb.
4. **Early release.**
   - Stimulus: OWN0 with src0_req dropped after 1 frame, src1_req high.
   - Required: switch to OWN1 at the next fb. If src1_req is also low instead: go to IDLE, grants 0, count_val holds the last value.
5. **Mid-operation reset.**
   - Stimulus: assert rst for 1 cycle while OWN1 and dig_pointer=2.
   - Required: on the next edge, dig_pointer=0, count_val=0000, src1_gnt=0, frame_done=0. Scan restarts from div_cnt=0.
6. **Sub-frame pulse.**
   - Stimulus: 3-cycle src1_req pulse that does not cover an fb.
   - Required: no grant, state stays IDLE.
